hybrid_branch_predictor: RTL and testbench
==========================================

# hybrid_branch_predictor

Parametrised direction predictor for the fetch stage with three runtime-fixed modes: bimodal, gshare and tournament (bimodal plus gshare with a per-PC chooser). Each table uses saturating 2-bit counters. The global history register (GHR) is updated speculatively and repaired from a history snapshot that travels down the pipeline with each branch. After reset, a sweep state machine initialises all tables, and the block keeps branch and mispredict statistics. Fetch drives the lookup side; the ALU stage drives the resolve side.

## Interface
- `PC_WIDTH`, 22: width of instruction word address.
- `INDEX_BITS`, 8: log2 of entries per table (bimodal, gshare, chooser).
- `HIST_BITS`, 8: GHR length; must be ≤ `INDEX_BITS`.
- `MODE`, 2: 0 = bimodal, 1 = gshare, 2 = tournament.
- `CNT_WIDTH`, 32: statistics counter width.

- `i_Clk`, in, 1: clock, rising edge.
- `i_Reset_n`, in, 1: reset, asynchronous, active-low.
- `i_IMEM_address`, in, `PC_WIDTH`: word address of the instruction being fetched.
- `i_IMEM_isbranch`, in, 1: predecode says the fetched instruction is a conditional branch.
- `o_taken`, out, 1: prediction for `i_IMEM_address`.
- `o_ghr`, out, `HIST_BITS`: GHR value used for this prediction; the pipeline carries it to ALU.
- `o_pred_bits`, out, 2: {gshare_pred, bimodal_pred}; the pipeline carries it to ALU.
- `o_ready`, out, 1: tables initialised; predictions are valid.
- `i_ALU_isbranch`, in, 1: the instruction in ALU is a resolved conditional branch.
- `i_ALU_pc`, in, `PC_WIDTH`: its address.
- `i_ALU_outcome`, in, 1: 1 = taken.
- `i_ALU_prediction`, in, 1: the `o_taken` value it received.
- `i_ALU_ghr`, in, `HIST_BITS`: the `o_ghr` value it received.
- `i_ALU_pred_bits`, in, 2: the `o_pred_bits` value it received.
- `o_branch_count`, out, `CNT_WIDTH`: resolved branches.
- `o_mispredict_count`, out, `CNT_WIDTH`: resolved mispredictions.

## Operation
- **States:** INIT, RUN.
  - Reset forces INIT with sweep pointer = 0.
  - INIT writes bimodal = 2'b10, gshare = 2'b10, chooser = 2'b01 at the pointer, then increments the pointer.
  - After entry 2^`INDEX_BITS`−1 is written, the next state is RUN.
- **Indexing:**
  - bidx = `i_IMEM_address[INDEX_BITS-1:0]`.
  - gidx = bidx ^ zero-extended GHR.
  - The resolve side uses the same functions on `i_ALU_pc` and `i_ALU_ghr`.
- **Prediction (combinational, RUN only):**
  - bimodal_pred = bimodal[bidx][1].
  - gshare_pred = gshare[gidx][1].
  - MODE 0 uses bimodal_pred and MODE 1 uses gshare_pred.
  - MODE 2 uses gshare_pred if chooser[bidx][1], else bimodal_pred.
  - In INIT, `o_taken` = 0.
- **Speculative history:** in RUN, when `i_IMEM_isbranch` is high and there is no ALU mispredict, GHR <= {GHR[H-2:0], o_taken}.
- **Resolve** (RUN, `i_ALU_isbranch` high):
  - Saturating counter update of the resolve-side bimodal and gshare entries, +1 if taken and −1 if not.
  - Counters clamp at 0 and 3; no wrap.
  - The chooser updates only when `i_ALU_pred_bits[1]` ≠ `i_ALU_pred_bits[0]`: +1 if the gshare bit equals the outcome, else −1, saturating.
  - MODE 0 and MODE 1 still train both tables; only the selection differs.
- **Repair:** when `i_ALU_isbranch` is high and outcome ≠ `i_ALU_prediction`, GHR <= {`i_ALU_ghr`[H-2:0], `i_ALU_outcome`}. Repair overrides any same-cycle speculative shift.
- **Statistics:**
  - `o_branch_count` increments on every resolve.
  - `o_mispredict_count` increments on every repair.
  - Both saturate at all-ones.
  - Both are cleared only by reset.
- **During INIT:** ALU inputs are ignored, GHR is held at 0 and the statistics are frozen.

## Timing
- **Reset values:**
  - `o_ready` = 0, `o_taken` = 0, `o_ghr` = 0, `o_pred_bits` = 0.
  - Both statistics counters = 0.
  - GHR = 0.
- **Init length:** `o_ready` rises exactly 2^`INDEX_BITS` cycles after reset deassertion (256 at default).
- **Lookup latency:** `o_taken`, `o_ghr` and `o_pred_bits` are combinational from `i_IMEM_address` and registered state in the same cycle.
- **Update visibility:**
  - Table writes and the GHR update take effect at the next rising edge.
  - A same-cycle lookup of an entry being written sees the old value.
- **Reset mid-operation:** an asynchronous assert immediately returns all outputs to their reset values and the state to INIT. The sweep restarts from 0.
- **Simultaneous events:** a lookup shift and a resolve in the same cycle with a correct prediction produces the speculative shift only. With a mispredict, it produces the repair only.
- **Chooser write:** a gshare/bimodal agreement causes no chooser write.

## Test plan
- **Reset and init:** deassert `i_Reset_n` → `o_ready` = 0 for 256 cycles, then 1. The first lookup at address 0x05 gives `o_taken` = 1 (2'b10), `o_pred_bits` = 2'b11.
- **Saturation:** resolve address 0x10 as not-taken 4 times → bimodal[0x10] = 0. One taken resolve → 1 and the prediction is still 0. A further 5 taken resolves → 3, not wrapping to 0.
- **Speculative shift and repair:**
  - Look up 3 branches predicted 1 from GHR 0 → `o_ghr` = 0x07.
  - Resolve with `i_ALU_ghr` = 0x01, prediction 1, outcome 0 → next-cycle GHR = 0x02, overriding a same-cycle fetch shift.
  - `o_mispredict_count` = 1.
- **Tournament chooser:**
  - In MODE 2, `i_ALU_pred_bits` = 2'b10 with outcome 1, repeated twice → chooser[idx] reaches 3 and lookups select gshare.
  - With pred_bits 2'b11, the chooser is unchanged.
- **gshare aliasing:** with GHR = 0xFF, address 0x0F maps to gidx 0xF0. Train 0xF0 to 0 via the resolve path → the lookup of 0x0F predicts 0 in MODE 1 while bimodal still predicts 1.
- **Reset mid-run:** assert reset after 50 resolves → counters = 0, GHR = 0 and `o_ready` = 0 immediately. A full 256-cycle sweep is then required.

Source files
------------

// File: rtl/hybrid_branch_predictor_if.sv
// Fetch-side lookup and ALU-side resolve signals of the branch direction predictor.
// Master is the pipeline (fetch + ALU); slave is the predictor.
interface hybrid_branch_predictor_if #(
    parameter int PC_WIDTH  = 22,
    parameter int HIST_BITS = 8,
    parameter int CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  i_IMEM_address;
    logic                 i_IMEM_isbranch;
    logic                 o_taken;
    logic [HIST_BITS-1:0] o_ghr;
    logic [1:0]           o_pred_bits;
    logic                 o_ready;

    logic                 i_ALU_isbranch;
    logic [PC_WIDTH-1:0]  i_ALU_pc;
    logic                 i_ALU_outcome;
    logic                 i_ALU_prediction;
    logic [HIST_BITS-1:0] i_ALU_ghr;
    logic [1:0]           i_ALU_pred_bits;

    logic [CNT_WIDTH-1:0] o_branch_count;
    logic [CNT_WIDTH-1:0] o_mispredict_count;

    modport master (
        output i_IMEM_address, i_IMEM_isbranch,
               i_ALU_isbranch, i_ALU_pc, i_ALU_outcome, i_ALU_prediction,
               i_ALU_ghr, i_ALU_pred_bits,
        input  o_taken, o_ghr, o_pred_bits, o_ready,
               o_branch_count, o_mispredict_count
    );

    modport slave (
        input  i_IMEM_address, i_IMEM_isbranch,
               i_ALU_isbranch, i_ALU_pc, i_ALU_outcome, i_ALU_prediction,
               i_ALU_ghr, i_ALU_pred_bits,
        output o_taken, o_ghr, o_pred_bits, o_ready,
               o_branch_count, o_mispredict_count
    );
endinterface

// File: rtl/hybrid_branch_predictor.sv
// Bimodal / gshare / tournament direction predictor with speculative GHR,
// snapshot-based repair, post-reset table sweep and resolve statistics.
module hybrid_branch_predictor #(
    parameter int PC_WIDTH   = 22,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int MODE       = 2,
    parameter int CNT_WIDTH  = 32
) (
    input logic                   i_Clk,
    input logic                   i_Reset_n,
    hybrid_branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                 state_q;
    logic [INDEX_BITS-1:0]  ptr_q;
    logic                   ready_q;
    logic [HIST_BITS-1:0]   ghr_q, ghr_d;
    logic [CNT_WIDTH-1:0]   bcnt_q, mcnt_q;

    logic [1:0] bim_q [ENTRIES];
    logic [1:0] gsh_q [ENTRIES];
    logic [1:0] cho_q [ENTRIES];

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup side
    logic [INDEX_BITS-1:0] l_bidx, l_gidx;
    logic                  bim_pred, gsh_pred, sel_pred;

    assign l_bidx   = bus.i_IMEM_address[INDEX_BITS-1:0];
    assign l_gidx   = l_bidx ^ INDEX_BITS'(ghr_q);
    assign bim_pred = bim_q[l_bidx][1];
    assign gsh_pred = gsh_q[l_gidx][1];

    always_comb begin
        sel_pred = bim_pred;
        if (MODE == 1)      sel_pred = gsh_pred;
        else if (MODE == 2) sel_pred = cho_q[l_bidx][1] ? gsh_pred : bim_pred;
    end

    assign bus.o_taken            = ready_q & sel_pred;
    assign bus.o_pred_bits        = ready_q ? {gsh_pred, bim_pred} : 2'b00;
    assign bus.o_ghr              = ghr_q;
    assign bus.o_ready            = ready_q;
    assign bus.o_branch_count     = bcnt_q;
    assign bus.o_mispredict_count = mcnt_q;

    // Resolve side; everything here is gated off while the sweep runs
    logic [INDEX_BITS-1:0] r_bidx, r_gidx;
    logic                  res_en, mispred;

    assign r_bidx  = bus.i_ALU_pc[INDEX_BITS-1:0];
    assign r_gidx  = r_bidx ^ INDEX_BITS'(bus.i_ALU_ghr);
    assign res_en  = ready_q & bus.i_ALU_isbranch;
    assign mispred = res_en & (bus.i_ALU_outcome != bus.i_ALU_prediction);

    // Repair wins over a same-cycle speculative shift
    always_comb begin
        ghr_d = ghr_q;
        if (mispred)
            ghr_d = {bus.i_ALU_ghr[HIST_BITS-2:0], bus.i_ALU_outcome};
        else if (ready_q && bus.i_IMEM_isbranch)
            ghr_d = {ghr_q[HIST_BITS-2:0], sel_pred};
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            ghr_q   <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ghr_q <= ghr_d;
                    if (res_en && bcnt_q != '1) bcnt_q <= bcnt_q + 1'b1;
                    if (mispred && mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Tables carry no reset: the sweep defines their contents before use
    always_ff @(posedge i_Clk) begin
        if (!ready_q) begin
            bim_q[ptr_q] <= 2'b10;
            gsh_q[ptr_q] <= 2'b10;
            cho_q[ptr_q] <= 2'b01;
        end else if (res_en) begin
            bim_q[r_bidx] <= sat2(bim_q[r_bidx], bus.i_ALU_outcome);
            gsh_q[r_gidx] <= sat2(gsh_q[r_gidx], bus.i_ALU_outcome);
            if (bus.i_ALU_pred_bits[1] != bus.i_ALU_pred_bits[0])
                cho_q[r_bidx] <= sat2(cho_q[r_bidx],
                                      bus.i_ALU_pred_bits[1] == bus.i_ALU_outcome);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.i_IMEM_address[PC_WIDTH-1:INDEX_BITS],
                           bus.i_ALU_pc[PC_WIDTH-1:INDEX_BITS],
                           bus.i_ALU_ghr[HIST_BITS-1]};
endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Randomized + directed bench for hybrid_branch_predictor with a queue-based
// scoreboard against a table-level reference model.
module tb_hybrid_branch_predictor;
    localparam int PCW   = 22;
    localparam int IB    = 8;
    localparam int HB    = 8;
    localparam int MODE  = 2;
    localparam int CW    = 32;
    localparam int N     = 1 << IB;
    localparam int HMASK = (1 << HB) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hybrid_branch_predictor_if #(.PC_WIDTH(PCW), .HIST_BITS(HB), .CNT_WIDTH(CW)) bif ();

    hybrid_branch_predictor #(
        .PC_WIDTH(PCW), .INDEX_BITS(IB), .HIST_BITS(HB), .MODE(MODE), .CNT_WIDTH(CW)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bif)
    );

    typedef struct {
        string         tag;
        logic          rdy;
        logic          taken;
        logic [HB-1:0] ghr;
        logic [1:0]    pb;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain integer tables, counters and a history value
    int            m_bim[N], m_gsh[N], m_cho[N];
    int            m_ghr, m_init_left;
    logic [CW-1:0] m_bc, m_mc;
    int            resolves_seen;

    function automatic int sat(int c, bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_bim[i] = 2; m_gsh[i] = 2; m_cho[i] = 1;
        end
        m_ghr = 0; m_init_left = N; m_bc = '0; m_mc = '0;
    endfunction

    task automatic cyc(string tag, bit rst, logic [PCW-1:0] addr, bit isbr,
                       bit alubr, logic [PCW-1:0] pc, bit out, bit pred,
                       logic [HB-1:0] ag, logic [1:0] apb);
        exp_t e;
        bif.i_IMEM_address   = addr;
        bif.i_IMEM_isbranch  = isbr;
        bif.i_ALU_isbranch   = alubr;
        bif.i_ALU_pc         = pc;
        bif.i_ALU_outcome    = out;
        bif.i_ALU_prediction = pred;
        bif.i_ALU_ghr        = ag;
        bif.i_ALU_pred_bits  = apb;
        rst_n                = rst;
        e.tag = tag;
        if (!rst) begin
            model_reset();
            e.rdy = 0; e.taken = 0; e.ghr = '0; e.pb = 2'b00; e.bc = '0; e.mc = '0;
        end else if (m_init_left > 0) begin
            e.rdy = 0; e.taken = 0; e.ghr = HB'(m_ghr); e.pb = 2'b00; e.bc = m_bc; e.mc = m_mc;
            m_init_left--;
        end else begin
            int bi, gi, rb, rg;
            bit bp, gp, tk;
            bi = int'(addr) & (N - 1);
            gi = bi ^ m_ghr;
            bp = m_bim[bi] >= 2;
            gp = m_gsh[gi] >= 2;
            tk = (MODE == 0) ? bp : (MODE == 1) ? gp : ((m_cho[bi] >= 2) ? gp : bp);
            e.rdy = 1; e.taken = tk; e.ghr = HB'(m_ghr); e.pb = {gp, bp};
            e.bc = m_bc; e.mc = m_mc;
            if (alubr) begin
                rb = int'(pc) & (N - 1);
                rg = rb ^ int'(ag);
                m_bim[rb] = sat(m_bim[rb], out);
                m_gsh[rg] = sat(m_gsh[rg], out);
                if (apb[1] != apb[0]) m_cho[rb] = sat(m_cho[rb], apb[1] == out);
                if (m_bc != '1) m_bc = m_bc + 1;
                resolves_seen++;
            end
            if (alubr && out != pred) begin
                if (m_mc != '1) m_mc = m_mc + 1;
                m_ghr = ((int'(ag) << 1) | int'(out)) & HMASK;
            end else if (isbr) begin
                m_ghr = ((m_ghr << 1) | int'(tk)) & HMASK;
            end
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic look(string tag, logic [PCW-1:0] addr, bit isbr);
        cyc(tag, 1, addr, isbr, 0, '0, 0, 0, '0, 2'b00);
    endtask

    task automatic res(string tag, logic [PCW-1:0] pc, bit out, bit pred,
                       logic [HB-1:0] ag, logic [1:0] apb);
        cyc(tag, 1, '0, 0, 1, pc, out, pred, ag, apb);
    endtask

    task automatic rnd(string tag, bit rst);
        logic [PCW-1:0] a, p;
        bit o;
        a = PCW'($urandom);
        p = PCW'($urandom);
        if ($urandom_range(0, 1) == 0) a[IB-1:0] = IB'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) p[IB-1:0] = IB'($urandom_range(0, 15));
        o = 1'($urandom);
        cyc(tag, rst, a, 1'($urandom), 1'($urandom), p, o,
            ($urandom_range(0, 3) == 0) ? ~o : o, HB'($urandom), 2'($urandom));
    endtask

    task automatic chk(string tag, string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are compared at the falling edge, away from updates
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk(e.tag, "ready", 64'(bif.o_ready), 64'(e.rdy));
                chk(e.tag, "taken", 64'(bif.o_taken), 64'(e.taken));
                chk(e.tag, "pred_bits", 64'(bif.o_pred_bits), 64'(e.pb));
                chk(e.tag, "ghr", 64'(bif.o_ghr), 64'(e.ghr));
                chk(e.tag, "branch_cnt", 64'(bif.o_branch_count), 64'(e.bc));
                chk(e.tag, "mispred_cnt", 64'(bif.o_mispredict_count), 64'(e.mc));
            end
        end
    end

    initial begin
        bif.i_IMEM_address = '0; bif.i_IMEM_isbranch = 0; bif.i_ALU_isbranch = 0;
        bif.i_ALU_pc = '0; bif.i_ALU_outcome = 0; bif.i_ALU_prediction = 0;
        bif.i_ALU_ghr = '0; bif.i_ALU_pred_bits = 2'b00;
        resolves_seen = 0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rnd("reset", 0);
        // Sweep with ALU noise that must be ignored
        for (int i = 0; i < N; i++) rnd("init", 1);
        look("first_0x05", 22'h05, 0);

        for (int i = 0; i < 4; i++) res("sat_nt", 22'h10, 0, 0, '0, 2'b00);
        look("sat_low", 22'h10, 0);
        res("sat_t1", 22'h10, 1, 1, '0, 2'b00);
        look("sat_one", 22'h10, 0);
        for (int i = 0; i < 5; i++) res("sat_t", 22'h10, 1, 1, '0, 2'b00);
        look("sat_high", 22'h10, 0);

        res("ghr_zero", 22'h40, 0, 1, '0, 2'b00);
        look("spec0", 22'h20, 1);
        look("spec1", 22'h21, 1);
        look("spec2", 22'h22, 1);
        look("spec_ghr7", 22'h23, 0);
        cyc("repair", 1, 22'h24, 1, 1, 22'h50, 0, 1, 8'h01, 2'b00);
        look("repair_ghr2", 22'h25, 0);

        res("cho_up0", 22'h30, 1, 1, '0, 2'b10);
        res("cho_up1", 22'h30, 1, 1, '0, 2'b10);
        for (int i = 0; i < 4; i++) res("bim_dn", 22'h30, 0, 0, 8'h55, 2'b11);
        look("cho_sel", 22'h30, 0);

        res("ghr_ff", 22'h00, 1, 0, 8'h7F, 2'b00);
        res("alias_tr0", 22'hF0, 0, 0, '0, 2'b00);
        res("alias_tr1", 22'hF0, 0, 0, '0, 2'b00);
        look("alias_0x0F", 22'h0F, 0);

        for (int i = 0; i < 1500; i++) rnd("rand", 1);

        resolves_seen = 0;
        for (int i = 0; i < 1000 && resolves_seen < 50; i++) rnd("pre_rst", 1);
        rnd("midrst", 0);
        rnd("midrst", 0);
        for (int i = 0; i < N + 2; i++) rnd("resweep", 1);
        for (int i = 0; i < 600; i++) rnd("rand2", 1);

        @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
